// File: rtl/pcie_cfg_mgmt_arb_if.sv
// Bundle of signals between the cfg_mgmt arbiter, its requesters and the PCIe core.
// The master modport is the arbiter's view. The slave modport is the view of the
// requesters and the core together.
interface pcie_cfg_mgmt_arb_if #(
  parameter int PORTS = 4
);
  // requester side
  logic [PORTS-1:0]    s_req_valid;
  logic [PORTS-1:0]    s_req_ready;
  logic [PORTS-1:0]    s_req_write;
  logic [PORTS*10-1:0] s_req_addr;
  logic [PORTS*8-1:0]  s_req_func;
  logic [PORTS*32-1:0] s_req_data;
  logic [PORTS*4-1:0]  s_req_be;
  logic [PORTS-1:0]    m_rsp_valid;
  logic [31:0]         m_rsp_data;
  logic                m_rsp_timeout;
  // hard-IP cfg_mgmt side
  logic [9:0]          cfg_mgmt_addr;
  logic [7:0]          cfg_mgmt_function_number;
  logic                cfg_mgmt_write;
  logic [31:0]         cfg_mgmt_write_data;
  logic [3:0]          cfg_mgmt_byte_enable;
  logic                cfg_mgmt_read;
  logic [31:0]         cfg_mgmt_read_data;
  logic                cfg_mgmt_read_write_done;

  modport master (
    input  s_req_valid, s_req_write, s_req_addr, s_req_func, s_req_data, s_req_be,
    output s_req_ready, m_rsp_valid, m_rsp_data, m_rsp_timeout,
    output cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
    output cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read,
    input  cfg_mgmt_read_data, cfg_mgmt_read_write_done
  );

  modport slave (
    output s_req_valid, s_req_write, s_req_addr, s_req_func, s_req_data, s_req_be,
    input  s_req_ready, m_rsp_valid, m_rsp_data, m_rsp_timeout,
    input  cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
    input  cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read,
    output cfg_mgmt_read_data, cfg_mgmt_read_write_done
  );
endinterface

// File: rtl/pcie_cfg_mgmt_arb.sv
// Round-robin arbiter for the single PCIe hard-IP cfg_mgmt port.
// It runs one access at a time. The strobe is held until the core reports done or the
// timeout expires. The result returns to the requester that owns the access.
module pcie_cfg_mgmt_arb #(
  parameter int PORTS   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  pcie_cfg_mgmt_arb_if.master        bus
);

  localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]   P_PORTS_EXT = (PTR_W + 1)'(PORTS);
  localparam logic [PTR_W-1:0] P_LAST_PORT = PTR_W'(PORTS - 1);
  localparam logic [CNT_W-1:0] P_CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [PTR_W-1:0]   r_rr;
  logic [PTR_W-1:0]   r_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_write;
  logic               r_read;
  logic               r_write;
  logic [9:0]         r_addr;
  logic [7:0]         r_func;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic [PORTS-1:0]   r_rsp_valid;
  logic [31:0]        r_rsp_data;
  logic               r_rsp_timeout;

  logic [PTR_W:0]     w_sum;
  logic [PTR_W-1:0]   w_cand;
  logic               w_hit;
  logic               w_found;
  logic [PTR_W-1:0]   w_grant;
  logic [PTR_W-1:0]   w_rr_nxt;
  logic               w_accept;
  logic               w_done;
  logic               w_expire;
  logic               w_sel_write;
  logic [9:0]         w_sel_addr;
  logic [7:0]         w_sel_func;
  logic [31:0]        w_sel_data;
  logic [3:0]         w_sel_be;

  // Decode a port index into its one-hot requester lane.
  function automatic logic [PORTS-1:0] f_onehot(input logic [PTR_W-1:0] idx);
    logic [PORTS-1:0] v;
    v = {PORTS{1'b0}};
    for (int k = 0; k < PORTS; k++) begin
      v[k] = (PTR_W'(k) == idx);
    end
    return v;
  endfunction

  // Round-robin search: the first valid requester at or above the pointer, wrapping.
  always_comb begin
    w_sum   = {(PTR_W + 1){1'b0}};
    w_cand  = {PTR_W{1'b0}};
    w_hit   = 1'b0;
    w_found = 1'b0;
    w_grant = {PTR_W{1'b0}};
    for (int k = 0; k < PORTS; k++) begin
      w_sum   = {1'b0, r_rr} + (PTR_W + 1)'(k);
      w_cand  = (w_sum >= P_PORTS_EXT) ? PTR_W'(w_sum - P_PORTS_EXT) : PTR_W'(w_sum);
      w_hit   = !w_found && bus.s_req_valid[w_cand];
      w_grant = w_hit ? w_cand : w_grant;
      w_found = w_found | w_hit;
    end
  end

  // Select the request fields of the winning port for capture.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = 10'h000;
    w_sel_func  = 8'h00;
    w_sel_data  = 32'h0000_0000;
    w_sel_be    = 4'h0;
    for (int k = 0; k < PORTS; k++) begin
      w_sel_write = (PTR_W'(k) == w_grant) ? bus.s_req_write[k]         : w_sel_write;
      w_sel_addr  = (PTR_W'(k) == w_grant) ? bus.s_req_addr[k*10 +: 10] : w_sel_addr;
      w_sel_func  = (PTR_W'(k) == w_grant) ? bus.s_req_func[k*8 +: 8]   : w_sel_func;
      w_sel_data  = (PTR_W'(k) == w_grant) ? bus.s_req_data[k*32 +: 32] : w_sel_data;
      w_sel_be    = (PTR_W'(k) == w_grant) ? bus.s_req_be[k*4 +: 4]     : w_sel_be;
    end
  end

  // Accept, completion and expiry qualifiers, and the next-state decode.
  // Done takes priority over expiry in the same cycle. Accepts are blocked while in reset.
  always_comb begin
    w_accept    = rst_n && (r_state == ST_IDLE) && w_found;
    w_done      = (r_state == ST_BUSY) && bus.cfg_mgmt_read_write_done;
    w_expire    = (r_state == ST_BUSY) && !bus.cfg_mgmt_read_write_done && (r_cnt == P_CNT_LAST);
    w_rr_nxt    = (w_grant == P_LAST_PORT) ? {PTR_W{1'b0}} : (w_grant + PTR_W'(1));
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_accept ? ST_BUSY : ST_IDLE;
      ST_BUSY: w_state_nxt = (w_done || w_expire) ? ST_RESP : ST_BUSY;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Access datapath: capture on grant, hold the strobe while busy, build the response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr          <= {PTR_W{1'b0}};
      r_grant       <= {PTR_W{1'b0}};
      r_cnt         <= {CNT_W{1'b0}};
      r_is_write    <= 1'b0;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_addr        <= 10'h000;
      r_func        <= 8'h00;
      r_wdata       <= 32'h0000_0000;
      r_be          <= 4'h0;
      r_rsp_valid   <= {PORTS{1'b0}};
      r_rsp_data    <= 32'h0000_0000;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= {PORTS{1'b0}};
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_grant    <= w_grant;
            r_rr       <= w_rr_nxt;
            r_is_write <= w_sel_write;
            r_read     <= ~w_sel_write;
            r_write    <= w_sel_write;
            r_addr     <= w_sel_addr;
            r_func     <= w_sel_func;
            r_wdata    <= w_sel_data;
            r_be       <= w_sel_be;
            r_cnt      <= {CNT_W{1'b0}};
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_done) begin
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_rsp_data    <= r_is_write ? 32'h0000_0000 : bus.cfg_mgmt_read_data;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= f_onehot(r_grant);
          end else if (w_expire) begin
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_rsp_data    <= r_is_write ? 32'h0000_0000 : 32'hFFFF_FFFF;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= f_onehot(r_grant);
          end
        end
        ST_RESP: r_cnt <= {CNT_W{1'b0}};
        default: r_cnt <= {CNT_W{1'b0}};
      endcase
    end
  end

  assign bus.s_req_ready              = w_accept ? f_onehot(w_grant) : {PORTS{1'b0}};
  assign bus.m_rsp_valid              = r_rsp_valid;
  assign bus.m_rsp_data               = r_rsp_data;
  assign bus.m_rsp_timeout            = r_rsp_timeout;
  assign bus.cfg_mgmt_addr            = r_addr;
  assign bus.cfg_mgmt_function_number = r_func;
  assign bus.cfg_mgmt_write           = r_write;
  assign bus.cfg_mgmt_write_data      = r_wdata;
  assign bus.cfg_mgmt_byte_enable     = r_be;
  assign bus.cfg_mgmt_read            = r_read;

endmodule

// File: tb/tb_pcie_cfg_mgmt_arb.sv
// Bench for pcie_cfg_mgmt_arb.
// Directed requests push their expected responses onto a queue. A monitor on the
// falling edge pops that queue and compares each response pulse against it.
// A small core model answers the strobes after a programmable latency.
module tb_pcie_cfg_mgmt_arb;
  localparam int PORTS   = 4;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst_n;

  pcie_cfg_mgmt_arb_if #(.PORTS(PORTS)) bus ();

  pcie_cfg_mgmt_arb #(.PORTS(PORTS), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        tmo;
  } exp_t;

  exp_t        exp_q[$];
  int          grant_log[$];
  int          checks    = 0;
  int          errors    = 0;
  int          rsp_count = 0;
  int          last_len  = 0;
  int          core_lat  = 0;
  logic [31:0] core_data = 32'h0;
  logic        late_req  = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int port, input logic [31:0] data, input logic tmo);
    exp_t e;
    e.port = port;
    e.data = data;
    e.tmo  = tmo;
    exp_q.push_back(e);
  endtask

  // Core model: it asserts done in the core_lat-th strobe cycle. A latency of 0 means it never answers.
  initial begin : core_model
    int  strobe_cnt;
    logic auto_done;
    strobe_cnt = 0;
    bus.cfg_mgmt_read_write_done = 1'b0;
    bus.cfg_mgmt_read_data       = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.cfg_mgmt_read || bus.cfg_mgmt_write) strobe_cnt++;
      else strobe_cnt = 0;
      auto_done = (core_lat != 0) && (strobe_cnt == core_lat);
      bus.cfg_mgmt_read_write_done = auto_done || late_req;
      bus.cfg_mgmt_read_data       = auto_done ? core_data : (late_req ? 32'hDEAD_BEEF : 32'h0);
      late_req = 1'b0;
    end
  end

  // Monitor: grant log, strobe shape and stability checks, response scoreboard.
  initial begin : monitor
    logic        prev_st;
    logic        st;
    logic        stable;
    logic        seen_strobe;
    int          len;
    int          gap;
    logic [55:0] snap;
    logic [55:0] cur;
    exp_t        e;
    prev_st = 1'b0; stable = 1'b1; seen_strobe = 1'b0; len = 0; gap = 0; snap = 56'h0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < PORTS; k++) begin
        if (bus.s_req_ready[k]) grant_log.push_back(k);
      end
      if (bus.cfg_mgmt_read && bus.cfg_mgmt_write) chk("strobe_overlap", 32'd1, 32'd0);
      st  = bus.cfg_mgmt_read | bus.cfg_mgmt_write;
      cur = {bus.cfg_mgmt_addr, bus.cfg_mgmt_function_number, bus.cfg_mgmt_write_data,
             bus.cfg_mgmt_byte_enable, bus.cfg_mgmt_write, bus.cfg_mgmt_read};
      if (st && !prev_st) begin
        if (seen_strobe) chk("strobe_gap_ge2", 32'(gap >= 2), 32'd1);
        len = 1; stable = 1'b1; snap = cur; seen_strobe = 1'b1;
      end else if (st) begin
        len++;
        if (cur != snap) stable = 1'b0;
      end else if (prev_st) begin
        last_len = len;
        gap = 1;
        chk("strobe_fields_stable", 32'(stable), 32'd1);
      end else begin
        gap++;
      end
      prev_st = st;
      if (|bus.m_rsp_valid) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          chk("spurious_rsp", 32'(bus.m_rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid", 32'(bus.m_rsp_valid), 32'd1 << e.port);
          chk("rsp_data", bus.m_rsp_data, e.data);
          chk("rsp_timeout", 32'(bus.m_rsp_timeout), 32'(e.tmo));
        end
      end
    end
  end

  task automatic issue(input int p, input logic wr, input logic [9:0] addr, input logic [7:0] func,
                       input logic [31:0] data, input logic [3:0] be);
    logic got;
    got = 1'b0;
    bus.s_req_write[p]          = wr;
    bus.s_req_addr[p*10 +: 10]  = addr;
    bus.s_req_func[p*8 +: 8]    = func;
    bus.s_req_data[p*32 +: 32]  = data;
    bus.s_req_be[p*4 +: 4]      = be;
    bus.s_req_valid[p]          = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.s_req_ready[p]) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.s_req_valid[p] = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (grant_log.size() >= n) break;
    end
    if (i == budget) chk("grant_wait_timeout", 32'(grant_log.size()), 32'(n));
  endtask

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    if (i == budget) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stim
    int exp_order[6];
    int rsp_before;
    exp_order = '{0, 1, 3, 0, 1, 3};
    rst_n = 1'b0;
    bus.s_req_valid = 4'b0001;
    bus.s_req_write = 4'b0000;
    bus.s_req_addr  = 40'h0;
    bus.s_req_func  = 32'h0;
    bus.s_req_data  = 128'h0;
    bus.s_req_be    = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read", 32'(bus.cfg_mgmt_read), 32'd0);
    chk("rst_write", 32'(bus.cfg_mgmt_write), 32'd0);
    chk("rst_rsp_valid", 32'(bus.m_rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.m_rsp_data, 32'd0);
    chk("rst_rsp_timeout", 32'(bus.m_rsp_timeout), 32'd0);
    chk("rst_ready", 32'(bus.s_req_ready), 32'd0);
    chk("rst_addr", 32'(bus.cfg_mgmt_addr), 32'd0);
    @(posedge clk);
    #1;
    bus.s_req_valid = 4'b0000;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ports 0, 1 and 3 request continuously. Port 1 writes, the others read.
    core_lat = 3;
    core_data = 32'hA5A5_0001;
    bus.s_req_addr[0 +: 10]  = 10'h010;
    bus.s_req_write[1]       = 1'b1;
    bus.s_req_addr[10 +: 10] = 10'h011;
    bus.s_req_data[32 +: 32] = 32'h1111_1111;
    bus.s_req_be[4 +: 4]     = 4'hF;
    bus.s_req_addr[30 +: 10] = 10'h013;
    for (int r = 0; r < 2; r++) begin
      push_exp(0, 32'hA5A5_0001, 1'b0);
      push_exp(1, 32'h0000_0000, 1'b0);
      push_exp(3, 32'hA5A5_0001, 1'b0);
    end
    grant_log.delete();
    bus.s_req_valid = 4'b1011;
    wait_grants(6, 200);
    bus.s_req_valid = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      chk("rr_order", 32'((i < grant_log.size()) ? grant_log[i] : 99), 32'(exp_order[i]));
    end
    wait_drain(100);

    // A single read on port 2, answered in the 5th strobe cycle.
    core_lat = 5;
    core_data = 32'h10EE_9038;
    push_exp(2, 32'h10EE_9038, 1'b0);
    issue(2, 1'b0, 10'h004, 8'h00, 32'h0, 4'h0);
    wait_drain(50);
    chk("read_strobe_len", 32'(last_len), 32'd5);
    repeat (2) @(posedge clk);
    #1;
    chk("rsp_data_hold", bus.m_rsp_data, 32'h10EE_9038);

    // A write on port 1. The strobe fields must match the request.
    core_lat = 4;
    push_exp(1, 32'h0000_0000, 1'b0);
    issue(1, 1'b1, 10'h001, 8'h02, 32'h0000_0406, 4'b0011);
    @(negedge clk);
    chk("wr_strobe", 32'(bus.cfg_mgmt_write), 32'd1);
    chk("wr_no_read", 32'(bus.cfg_mgmt_read), 32'd0);
    chk("wr_addr", 32'(bus.cfg_mgmt_addr), 32'h001);
    chk("wr_func", 32'(bus.cfg_mgmt_function_number), 32'h02);
    chk("wr_data", bus.cfg_mgmt_write_data, 32'h0000_0406);
    chk("wr_be", 32'(bus.cfg_mgmt_byte_enable), 32'h3);
    wait_drain(50);
    chk("write_strobe_len", 32'(last_len), 32'd4);

    // The core never answers, so the access times out. A late done afterwards must be ignored.
    core_lat = 0;
    push_exp(3, 32'hFFFF_FFFF, 1'b1);
    issue(3, 1'b0, 10'h3FF, 8'h01, 32'h0, 4'h0);
    wait_drain(60);
    chk("timeout_strobe_len", 32'(last_len), 32'd16);
    rsp_before = rsp_count;
    repeat (2) @(posedge clk);
    @(negedge clk);
    late_req = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("late_done_ignored", 32'(rsp_count), 32'(rsp_before));
    chk("late_done_no_strobe", 32'(bus.cfg_mgmt_read | bus.cfg_mgmt_write), 32'd0);

    // The core answers in the final timeout cycle. Done wins, so the response is normal.
    core_lat = 16;
    core_data = 32'hCAFE_0005;
    push_exp(0, 32'hCAFE_0005, 1'b0);
    issue(0, 1'b0, 10'h020, 8'h00, 32'h0, 4'h0);
    wait_drain(60);
    chk("edge_strobe_len", 32'(last_len), 32'd16);

    // Reset while busy drops the access. Priority then restarts at port 0.
    core_lat = 0;
    issue(2, 1'b0, 10'h030, 8'h00, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_read", 32'(bus.cfg_mgmt_read), 32'd0);
    chk("mid_rst_write", 32'(bus.cfg_mgmt_write), 32'd0);
    chk("mid_rst_rsp_data", bus.m_rsp_data, 32'd0);
    rsp_before = rsp_count;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_rst_no_rsp", 32'(rsp_count), 32'(rsp_before));
    core_lat = 2;
    core_data = 32'h600D_0006;
    bus.s_req_write[0] = 1'b0;
    bus.s_req_write[3] = 1'b0;
    push_exp(0, 32'h600D_0006, 1'b0);
    push_exp(3, 32'h600D_0006, 1'b0);
    grant_log.delete();
    bus.s_req_valid = 4'b1001;
    wait_grants(2, 100);
    bus.s_req_valid = 4'b0000;
    chk("post_rst_first", 32'((grant_log.size() > 0) ? grant_log[0] : 99), 32'd0);
    chk("post_rst_second", 32'((grant_log.size() > 1) ? grant_log[1] : 99), 32'd3);
    wait_drain(100);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
